quad_signal_gen: RTL

- Quadrature A/B signal generator. It is the transmit-side counterpart of the position-counting quadrature decoder.
- Accepts a signed 32-bit target position and a per-phase dwell time.
- Emits A/B edges, one full quadrature cycle per count, until its internal position equals the target.
- Used as an encoder emulator for motion/thickness-gauge bring-up and as closed-loop stimulus for the decoder.

---
 rtl/quad_pkg.sv | 44 ++++
 rtl/quad_phase_stepper.sv | 67 ++++++
 rtl/quad_signal_gen.sv | 138 +++++++++++++
 3 files changed

// File: rtl/quad_pkg.sv
// Shared constants and helpers for the quadrature signal generator.
// Phase codes are {A,B}; position steps wrap to zero at the signed extremes.
package quad_pkg;

    localparam int MIN_DIV_DEF = 40;
    localparam int DIV_W_DEF   = 16;

    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_10 = 2'b10;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_01 = 2'b01;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    localparam logic [31:0] POS_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] POS_MIN = 32'h8000_0000;

    // Phase index 0..3 to {A,B}; UP leads with A, DOWN leads with B.
    function automatic logic [1:0] phase_bits(input logic [1:0] idx, input logic up);
        logic [1:0] ab;
        case (idx)
            2'd0:    ab = PH_00;
            2'd1:    ab = up ? PH_10 : PH_01;
            2'd2:    ab = PH_11;
            2'd3:    ab = up ? PH_01 : PH_10;
            default: ab = PH_00;
        endcase
        return ab;
    endfunction

    function automatic logic [31:0] pos_step(input logic [31:0] pos, input logic up);
        logic [31:0] nxt;
        if (up) begin
            nxt = (pos == POS_MAX) ? 32'd0 : pos + 32'd1;
        end else begin
            nxt = (pos == POS_MIN) ? 32'd0 : pos - 32'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/quad_phase_stepper.sv
// Walks the four quadrature phases with a fixed dwell per phase.
// count_done strobes on the edge that returns the outputs to 00.
module quad_phase_stepper
    import quad_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step_en,
    input  logic             dir,
    input  logic [DIV_W-1:0] div,
    output logic             sig_a,
    output logic             sig_b,
    output logic             count_done
);

    localparam logic [DIV_W-1:0] DWELL_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    logic [DIV_W-1:0] dwell_r;
    logic [1:0]       phase_r;
    logic             sig_a_r;
    logic             sig_b_r;
    logic             expire_s;
    logic [1:0]       phase_nxt_s;
    logic [1:0]       ab_nxt_s;

    // Phase expiry and the next {A,B} code.
    always_comb begin
        expire_s    = 1'b0;
        phase_nxt_s = phase_r + 2'd1;
        ab_nxt_s    = phase_bits(phase_nxt_s, dir);
        if (step_en) begin
            expire_s = (dwell_r == (div - DWELL_ONE));
        end else begin
            expire_s = 1'b0;
        end
    end

    assign count_done = expire_s && (phase_r == 2'd3);

    // Dwell counter, phase index and registered A/B outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dwell_r <= '0;
            phase_r <= 2'd0;
            sig_a_r <= 1'b0;
            sig_b_r <= 1'b0;
        end else if (!step_en) begin
            dwell_r <= '0;
            phase_r <= 2'd0;
            sig_a_r <= 1'b0;
            sig_b_r <= 1'b0;
        end else if (expire_s) begin
            dwell_r <= '0;
            phase_r <= phase_nxt_s;
            sig_a_r <= ab_nxt_s[1];
            sig_b_r <= ab_nxt_s[0];
        end else begin
            dwell_r <= dwell_r + DWELL_ONE;
        end
    end

    assign sig_a = sig_a_r;
    assign sig_b = sig_b_r;

endmodule

// File: rtl/quad_signal_gen.sv
// Quadrature encoder emulator: moves the emitted position to a signed target,
// one full A/B cycle per count, with abort honoured only at count boundaries.
module quad_signal_gen
    import quad_pkg::*;
#(
    parameter int MIN_DIV = MIN_DIV_DEF,
    parameter int DIV_W   = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_target,
    input  logic [DIV_W-1:0] cmd_div,
    input  logic             abort,
    output logic             sig_a,
    output logic             sig_b,
    output logic [31:0]      position,
    output logic             busy,
    output logic             done
);

    localparam logic [DIV_W-1:0] MIN_DIV_V = DIV_W'(MIN_DIV);

    state_t           state_r;
    logic [31:0]      target_r;
    logic [DIV_W-1:0] div_r;
    logic [31:0]      position_r;
    logic             dir_r;
    logic             abort_lat_r;
    logic             busy_r;
    logic             done_r;
    logic             cmd_ready_r;

    logic             accept_s;
    logic [DIV_W-1:0] div_clamp_s;
    logic [31:0]      pos_next_s;
    logic             finish_s;
    logic             dir_next_s;
    logic             step_en_s;
    logic             count_done_s;

    // Handshake, clamp and the decision taken at each count boundary.
    always_comb begin
        accept_s    = cmd_valid && cmd_ready_r && (state_r == ST_IDLE);
        div_clamp_s = cmd_div;
        if (cmd_div < MIN_DIV_V) begin
            div_clamp_s = MIN_DIV_V;
        end else begin
            div_clamp_s = cmd_div;
        end
        pos_next_s = pos_step(position_r, dir_r);
        finish_s   = (pos_next_s == target_r) || abort_lat_r || abort;
        dir_next_s = ($signed(target_r) > $signed(pos_next_s));
        step_en_s  = (state_r == ST_RUN);
    end

    quad_phase_stepper #(
        .DIV_W (DIV_W)
    ) u_stepper (
        .clk        (clk),
        .reset      (reset),
        .step_en    (step_en_s),
        .dir        (dir_r),
        .div        (div_r),
        .sig_a      (sig_a),
        .sig_b      (sig_b),
        .count_done (count_done_s)
    );

    // Move FSM, position register and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            target_r    <= 32'd0;
            div_r       <= MIN_DIV_V;
            position_r  <= 32'd0;
            dir_r       <= 1'b0;
            abort_lat_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            cmd_ready_r <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        target_r    <= cmd_target;
                        div_r       <= div_clamp_s;
                        cmd_ready_r <= 1'b0;
                        abort_lat_r <= 1'b0;
                        if (cmd_target == position_r) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= ST_RUN;
                            busy_r  <= 1'b1;
                            dir_r   <= ($signed(cmd_target) > $signed(position_r));
                        end
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        abort_lat_r <= 1'b1;
                    end
                    // Position moves on the same edge the outputs land back on 00.
                    if (count_done_s) begin
                        position_r <= pos_next_s;
                        if (finish_s) begin
                            state_r     <= ST_DONE;
                            busy_r      <= 1'b0;
                            done_r      <= 1'b1;
                            abort_lat_r <= 1'b0;
                        end else begin
                            dir_r <= dir_next_s;
                        end
                    end
                end
                ST_DONE: begin
                    state_r     <= ST_IDLE;
                    done_r      <= 1'b0;
                    cmd_ready_r <= 1'b1;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                    cmd_ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign position  = position_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign cmd_ready = cmd_ready_r;

endmodule
